// File: rtl/flit_pkg.sv
// Shared flit layout, opcodes and timing constants used by the router-side reduction blocks.
package flit_pkg;

  localparam int unsigned PayloadWidth = 64;
  localparam int unsigned FlitWidth    = PayloadWidth + 50;
  localparam int unsigned LgNumProcs   = 4;
  localparam int unsigned EntryWidth   = FlitWidth + LgNumProcs;

  localparam int unsigned OpPos        = PayloadWidth + 2;
  localparam int unsigned OpWidth      = 2;
  localparam int unsigned TagPos       = PayloadWidth + 6;
  localparam int unsigned TagWidth     = 8;
  localparam int unsigned ValidBitPos  = FlitWidth - 1;
  localparam int unsigned ChildrenPos  = FlitWidth;

  localparam int unsigned LoRsvdWidth  = OpPos - PayloadWidth;
  localparam int unsigned MidRsvdWidth = TagPos - (OpPos + OpWidth);
  localparam int unsigned HiRsvdWidth  = ValidBitPos - (TagPos + TagWidth);

  localparam int unsigned AdderLatency = 4;
  localparam int unsigned HoldCycles   = AdderLatency;
  localparam int unsigned TagIdxWidth  = 5;
  localparam int unsigned NumPorts     = 7;
  localparam int unsigned PortIdxWidth = 3;
  localparam int unsigned CntWidth     = 16;

  typedef enum logic [OpWidth-1:0] {
    OP_NONE   = 2'b00,
    OP_ADD    = 2'b01,
    OP_MAX    = 2'b10,
    OP_REDUCE = 2'b11
  } op_e;

  // Flit plus children count, MSB first.
  typedef struct packed {
    logic [LgNumProcs-1:0]   children;
    logic                    valid;
    logic [HiRsvdWidth-1:0]  hi_rsvd;
    logic [TagWidth-1:0]     tag;
    logic [MidRsvdWidth-1:0] mid_rsvd;
    logic [OpWidth-1:0]      op;
    logic [LoRsvdWidth-1:0]  lo_rsvd;
    logic [PayloadWidth-1:0] payload;
  } entry_t;

  typedef struct packed {
    logic                   v;
    logic [TagIdxWidth-1:0] idx;
  } sb_entry_t;

  function automatic logic [PortIdxWidth-1:0] next_port(input logic [PortIdxWidth-1:0] p);
    return (p == PortIdxWidth'(NumPorts - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/reduce_input_arbiter_tag_scoreboard.sv
// Tracks recently issued reduction-table indices and flags ports whose head flit
// targets a slot whose adder result is still in flight.
module tag_scoreboard
  import flit_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  logic [TagIdxWidth-1:0]          issue_idx,
  input  logic [NumPorts*TagIdxWidth-1:0] port_idx,
  output logic [NumPorts-1:0]             hazard_c
);

  // The issue cycle is the first hold cycle, so only the remaining ones are stored.
  localparam int unsigned Depth = HoldCycles - 1;

  sb_entry_t sb_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < Depth; s++) sb_q[s] <= '0;
    end else begin
      sb_q[0] <= '{v: issue_valid, idx: issue_idx};
      for (int s = 1; s < Depth; s++) sb_q[s] <= sb_q[s-1];
    end
  end

  // Parallel compare of every port's index against every live entry.
  always_comb begin
    hazard_c = '0;
    for (int p = 0; p < NumPorts; p++) begin
      for (int s = 0; s < Depth; s++) begin
        if (sb_q[s].v && (sb_q[s].idx == port_idx[p*TagIdxWidth +: TagIdxWidth])) begin
          hazard_c[p] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reduce_input_arbiter.sv
// Round-robin merge of the per-port receive FIFOs onto the reduce_unit input,
// holding off reduction flits whose table slot is still busy in the adder.
module reduce_input_arbiter
  import flit_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NumPorts*EntryWidth-1:0] req_entry,
  input  logic [NumPorts-1:0]          req_empty,
  output logic [NumPorts-1:0]          req_rd_en,
  input  logic                         ru_stall,
  output logic [EntryWidth-1:0]        out_entry,
  output logic                         out_valid,
  output logic [PortIdxWidth-1:0]      grant_port,
  output logic [CntWidth-1:0]          hazard_stalls
);

  entry_t                          port_entry [NumPorts];
  logic [NumPorts-1:0]             is_red_c;
  logic [NumPorts*TagIdxWidth-1:0] port_idx_c;
  logic [NumPorts-1:0]             hazard_c;
  logic [NumPorts-1:0]             eligible_c;
  logic [NumPorts-1:0]             blocked_c;

  logic                            grant_vld_c;
  logic [PortIdxWidth-1:0]         grant_idx_c;
  logic                            grant_en_c;
  logic                            issue_red_c;

  logic [PortIdxWidth-1:0]         rr_q, rr_d;
  entry_t                          out_entry_q, out_entry_d;
  logic                            out_valid_q, out_valid_d;
  logic [PortIdxWidth-1:0]         grant_port_q, grant_port_d;
  logic [CntWidth-1:0]             hazard_q, hazard_d;

  // Unpack each FIFO head and pull out the fields the arbiter needs.
  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign port_entry[p] = entry_t'(req_entry[p*EntryWidth +: EntryWidth]);
    assign is_red_c[p]   = port_entry[p].valid && (port_entry[p].op == OP_REDUCE);
    assign port_idx_c[p*TagIdxWidth +: TagIdxWidth] = port_entry[p].tag[TagIdxWidth-1:0];
  end

  tag_scoreboard u_tag_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_red_c),
    .issue_idx   (port_idx_c[grant_idx_c*TagIdxWidth +: TagIdxWidth]),
    .port_idx    (port_idx_c),
    .hazard_c    (hazard_c)
  );

  assign blocked_c  = ~req_empty & is_red_c & hazard_c;
  assign eligible_c = ~req_empty & ~(is_red_c & hazard_c);

  // First eligible port at or after rr_q, wrapping modulo NumPorts.
  always_comb begin
    logic [PortIdxWidth:0]   sum;
    logic [PortIdxWidth-1:0] cand;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    sum         = '0;
    cand        = '0;
    for (int off = 0; off < NumPorts; off++) begin
      sum = {1'b0, rr_q} + (PortIdxWidth+1)'(off);
      if (sum >= (PortIdxWidth+1)'(NumPorts)) sum = sum - (PortIdxWidth+1)'(NumPorts);
      cand = sum[PortIdxWidth-1:0];
      if (!grant_vld_c && eligible_c[cand]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand;
      end
    end
  end

  assign grant_en_c  = grant_vld_c && !ru_stall && !rst;
  assign issue_red_c = grant_en_c && is_red_c[grant_idx_c];

  always_comb begin
    req_rd_en = '0;
    if (grant_en_c) req_rd_en[grant_idx_c] = 1'b1;
  end

  always_comb begin
    rr_d         = rr_q;
    out_entry_d  = out_entry_q;
    out_valid_d  = 1'b0;
    grant_port_d = grant_port_q;
    hazard_d     = hazard_q;
    if (grant_en_c) begin
      rr_d         = next_port(grant_idx_c);
      out_entry_d  = port_entry[grant_idx_c];
      out_valid_d  = 1'b1;
      grant_port_d = grant_idx_c;
    end
    if ((|blocked_c) && !ru_stall && (hazard_q != '1)) hazard_d = hazard_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= '0;
      out_entry_q  <= '0;
      out_valid_q  <= 1'b0;
      grant_port_q <= '0;
      hazard_q     <= '0;
    end else begin
      rr_q         <= rr_d;
      out_entry_q  <= out_entry_d;
      out_valid_q  <= out_valid_d;
      grant_port_q <= grant_port_d;
      hazard_q     <= hazard_d;
    end
  end

  assign out_entry     = out_entry_q;
  assign out_valid     = out_valid_q;
  assign grant_port    = grant_port_q;
  assign hazard_stalls = hazard_q;

endmodule

// File: tb/tb_reduce_input_arbiter.sv
// Bench for reduce_input_arbiter: FIFO heads modelled as arrays, expected grants
// derived from per-index last-issue times and a plain round-robin search.
module tb_reduce_input_arbiter;

  localparam int NP    = 7;
  localparam int EW    = 118;
  localparam int HOLD  = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*EW-1:0]  req_entry;
  logic [NP-1:0]     req_empty;
  logic [NP-1:0]     req_rd_en;
  logic              ru_stall;
  logic [EW-1:0]     out_entry;
  logic              out_valid;
  logic [2:0]        grant_port;
  logic [15:0]       hazard_stalls;

  always #5 clk = ~clk;

  reduce_input_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_entry     (req_entry),
    .req_empty     (req_empty),
    .req_rd_en     (req_rd_en),
    .ru_stall      (ru_stall),
    .out_entry     (out_entry),
    .out_valid     (out_valid),
    .grant_port    (grant_port),
    .hazard_stalls (hazard_stalls)
  );

  logic [EW-1:0] mem [NP][DEPTH];
  int head [NP];
  int tail [NP];

  int            m_rr;
  logic          m_ov;
  logic [EW-1:0] m_oe;
  int            m_gp;
  int            m_hz;
  int            last_issue [32];
  int            grant_cyc [NP];
  int            cyc;
  int            rd_pulses;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] mk(input bit red, input logic [7:0] tag,
                                       input logic [63:0] pay, input logic [3:0] ch);
    logic [EW-1:0] e;
    e          = '0;
    e[63:0]    = pay;
    e[67:66]   = red ? 2'b11 : 2'b01;
    e[77:70]   = tag;
    e[113]     = 1'b1;
    e[117:114] = ch;
    return e;
  endfunction

  task automatic push(input int p, input logic [EW-1:0] e);
    mem[p][tail[p] % DEPTH] = e;
    tail[p]++;
  endtask

  function automatic bit is_red(input logic [EW-1:0] e);
    return e[113] && (e[67:66] == 2'b11);
  endfunction

  // One clock: drive FIFO heads, predict and check the pop, then check registered outputs.
  task automatic step(input bit stall, input bit r);
    int            g;
    int            p;
    int            idx;
    bit            any_haz;
    bit            hit;
    logic [NP-1:0] exp_rd;
    logic [EW-1:0] e;
    @(negedge clk);
    rst      = r;
    ru_stall = stall;
    for (int q = 0; q < NP; q++) begin
      req_empty[q]         = (head[q] == tail[q]);
      req_entry[q*EW +: EW] = (head[q] != tail[q]) ? mem[q][head[q] % DEPTH] : '0;
    end
    #1;
    g = -1;
    any_haz = 1'b0;
    if (!r) begin
      for (int off = 0; off < NP; off++) begin
        p = (m_rr + off) % NP;
        if (head[p] != tail[p]) begin
          e   = mem[p][head[p] % DEPTH];
          idx = int'(e[74:70]);
          hit = is_red(e) && (cyc - last_issue[idx] >= 1) && (cyc - last_issue[idx] <= HOLD - 1);
          if (hit) any_haz = 1'b1;
          else if (g < 0 && !stall) g = p;
        end
      end
    end
    exp_rd = (g >= 0) ? (NP'(1) << g) : '0;
    chk("req_rd_en", 128'(req_rd_en), 128'(exp_rd));
    if (req_rd_en != '0) rd_pulses++;

    @(posedge clk);
    #1;
    if (r) begin
      m_rr = 0; m_ov = 1'b0; m_oe = '0; m_gp = 0; m_hz = 0;
      for (int i = 0; i < 32; i++) last_issue[i] = -100;
    end else begin
      if (g >= 0) begin
        e = mem[g][head[g] % DEPTH];
        head[g]++;
        m_ov = 1'b1;
        m_oe = e;
        m_gp = g;
        m_rr = (g + 1) % NP;
        grant_cyc[g] = cyc;
        if (is_red(e)) last_issue[int'(e[74:70])] = cyc;
      end else begin
        m_ov = 1'b0;
      end
      if (any_haz && !stall && m_hz < 65535) m_hz++;
    end
    cyc++;
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("grant_port", 128'(grant_port), 128'(m_gp));
    chk("out_entry", 128'(out_entry), 128'(m_oe));
    chk("hazard_stalls", 128'(hazard_stalls), 128'(m_hz));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  logic [EW-1:0] f0;

  initial begin
    rst = 1'b1; ru_stall = 1'b0; req_entry = '0; req_empty = '1;
    m_rr = 0; m_ov = 1'b0; m_oe = '0; m_gp = 0; m_hz = 0; cyc = 0; rd_pulses = 0;
    for (int i = 0; i < 32; i++) last_issue[i] = -100;
    for (int p = 0; p < NP; p++) begin head[p] = 0; tail[p] = 0; grant_cyc[p] = -1; end

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_hazard", 128'(hazard_stalls), 128'(0));
    chk("rst_out_entry", 128'(out_entry), 128'(0));

    // Single reduction flit from port 0.
    f0 = mk(1'b1, 8'h03, 64'hDEAD_BEEF_0000_0001, 4'h2);
    push(0, f0);
    rd_pulses = 0;
    run(3);
    chk("t1_pops", 128'(rd_pulses), 128'(1));
    chk("t1_grant_cyc", 128'(grant_cyc[0]), 128'(2));

    // Non-reduction flits on ports 0, 2, 5 from rr_ptr 0.
    step(1'b0, 1'b1);
    push(0, mk(1'b0, 8'h01, 64'h10, 4'h0));
    push(2, mk(1'b0, 8'h01, 64'h12, 4'h0));
    push(5, mk(1'b0, 8'h01, 64'h15, 4'h0));
    run(1);
    chk("t2_first", 128'(grant_port), 128'(0));
    run(1);
    chk("t2_second", 128'(grant_port), 128'(2));
    run(1);
    chk("t2_third", 128'(grant_port), 128'(5));
    chk("t2_valid", 128'(out_valid), 128'(1));
    run(1);

    // Same idx on ports 1 and 3.
    step(1'b0, 1'b1);
    push(1, mk(1'b1, 8'h07, 64'h71, 4'h1));
    push(3, mk(1'b1, 8'h07, 64'h73, 4'h1));
    run(7);
    chk("t3_gap", 128'(grant_cyc[3] - grant_cyc[1]), 128'(4));
    chk("t3_hazard", 128'(hazard_stalls), 128'(3));

    // Different idx on ports 1 and 3.
    step(1'b0, 1'b1);
    push(1, mk(1'b1, 8'h07, 64'h81, 4'h1));
    push(3, mk(1'b1, 8'h08, 64'h83, 4'h1));
    run(3);
    chk("t4_gap", 128'(grant_cyc[3] - grant_cyc[1]), 128'(1));
    chk("t4_hazard", 128'(hazard_stalls), 128'(0));

    // Stall window ages an in-flight tag.
    step(1'b0, 1'b1);
    push(4, mk(1'b1, 8'h11, 64'h41, 4'h3));
    push(4, mk(1'b1, 8'h11, 64'h42, 4'h3));
    run(1);
    rd_pulses = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("t5_no_pop", 128'(rd_pulses), 128'(0));
    chk("t5_idle", 128'(out_valid), 128'(0));
    run(1);
    chk("t5_grant", 128'(grant_port), 128'(4));
    chk("t5_valid", 128'(out_valid), 128'(1));
    chk("t5_hazard", 128'(hazard_stalls), 128'(0));

    // Reset mid-traffic clears the scoreboard.
    step(1'b0, 1'b1);
    push(2, mk(1'b1, 8'h05, 64'h21, 4'h0));
    push(2, mk(1'b1, 8'h05, 64'h22, 4'h0));
    push(5, mk(1'b0, 8'h05, 64'h51, 4'h0));
    push(5, mk(1'b0, 8'h05, 64'h52, 4'h0));
    run(1);
    rd_pulses = 0;
    step(1'b0, 1'b1);
    chk("t6_no_pop", 128'(rd_pulses), 128'(0));
    chk("t6_rst_valid", 128'(out_valid), 128'(0));
    run(1);
    chk("t6_reissue", 128'(grant_port), 128'(2));
    chk("t6_payload", 128'(out_entry[63:0]), 128'(64'h22));
    run(4);

    // Mixed traffic with periodic stalls, checked cycle by cycle against the model.
    step(1'b0, 1'b1);
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < 5; k++) begin
        push(p, mk(((p + k) % 3) != 0, 8'((p * 3 + k) % 4 + 8 * (k % 2)),
                   64'((p << 8) | k), 4'(k)));
      end
    end
    for (int i = 0; i < 50; i++) step((i % 7) == 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
